pcnn_iter_ctrl: RTL
===================

// Module: pcnn_iter_ctrl
// PURPOSE
//  Parametrised sequencer for the PCNN image datapath. It owns all pixel and kernel counters internally.
//  Iteration runs a fixed sequence: load image, then N iterations of (neighbourhood accumulate -> neuron update), then stream pulses out.
//  Replaces externally counted row/col/shift flags with internal wrap counters, a runtime iteration count, valid/ready handshakes and abort.
// PARAMETERS
//  ROWS   8  image rows (>=2)
//  COLS   8  image columns (>=2)
//  KSIZE  3  odd kernel side; taps = KSIZE*KSIZE
//  IW     4  width of iteration count
//  RW/CW/KW  $clog2(ROWS)/$clog2(COLS)/$clog2(KSIZE), min 1: derived localparams, not overridable
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  go         in   1   start request, sampled only in IDLE
//  n_iter     in   IW  iteration count, latched on go; 0 treated as 1
//  abort      in   1   return to IDLE from any state next cycle
//  in_valid   in   1   stimulus pixel present
//  in_ready   out  1   controller accepting pixel (LOAD only)
//  out_valid  out  1   pulse pixel at (row,col) valid (OUT only)
//  out_ready  in   1   downstream accepts pulse pixel
//  row        out  RW  current pixel row
//  col        out  CW  current pixel column
//  krow,kcol  out  KW  current kernel tap; datapath applies -KSIZE/2 offset and border zeroing
//  ld_en      out  1   write stimulus at (row,col)
//  acc_clr    out  1   first tap of pixel: load accumulator instead of add
//  acc_en     out  1   accumulate tap (krow,kcol) for pixel (row,col)
//  upd_en     out  1   update feeding/linking/threshold/pulse at (row,col)
//  iter_cnt   out  IW  completed iterations
//  busy       out  1   state != IDLE
//  done       out  1   one-cycle pulse on completion
// BEHAVIOUR
//  Reset: state IDLE; row, col, krow, kcol and iter_cnt = 0; every output 0.
//  Moore style: outputs decode from registered state/counters. Handshakes: in_ready = (state==LOAD); out_valid = (state==OUT).
//  IDLE: go=1 -> LOAD; latch n_iter (0->1); clear all counters. go in any other state is ignored.
//  LOAD: ld_en = in_valid. Each accepted beat: col++; on col==COLS-1 col wraps to 0 and row++.
//    Beat at (ROWS-1,COLS-1) -> TAP with row=col=0. No transfer while in_valid=0; counters hold.
//  TAP: acc_en=1 every cycle; acc_clr=1 when krow=kcol=0. kcol steps, wraps and increments krow.
//    Tap (KSIZE-1,KSIZE-1) -> UPD.
//  UPD: one cycle, upd_en=1; advance pixel (same wrap as LOAD); clear krow/kcol.
//    Not last pixel -> TAP. Last pixel -> iter_cnt++.
//    If iter_cnt+1 == latched n_iter -> OUT with row=col=0; else -> TAP with row=col=0.
//  Cost per iteration: ROWS*COLS*(KSIZE*KSIZE+1) cycles. Each pixel sees a full sweep of old state (datapath double-buffers).
//  OUT: advance pixel on out_valid&out_ready; row/col held stable while stalled. Last beat -> DONE.
//  DONE: done=1 for exactly one cycle -> IDLE. iter_cnt holds until next go.
//  abort=1 in any non-IDLE state -> IDLE next edge, no done, counters cleared. Abort has priority over all transitions.
//  abort in IDLE has no effect; abort and go together in IDLE: go wins.
//  rst mid-operation: immediate return to reset values; no partial done.
//  Illegal state encodings -> IDLE.
// STRUCTURE
//  pcnn_ctrl_defs.vh: state localparams (IDLE,LOAD,TAP,UPD,OUT,DONE) and width helper macros; shared with the datapath and bench.
//  Sub-module pcnn_wrap_cnt2d #(N1,N0): 2-D counter with inc/clr, wrap and last flag.
//    Instantiated twice: pixel (ROWS,COLS) and kernel (KSIZE,KSIZE).
// TESTING
//  ROWS=COLS=4,KSIZE=3: reset -> all outputs 0. go with n_iter=2, in_valid=1 continuous
//    -> 16 ld_en beats, then 320 cycles TAP/UPD (32 upd_en), iter_cnt 0->1->2, then 16 out beats, done one cycle.
//  in_valid toggling 1/0 during LOAD -> exactly 16 ld_en; row/col advance only on accepted beats.
//  out_ready low 5 cycles at pixel (2,1) -> out_valid held, row=2, col=1 stable; still 16 total beats.
//  n_iter=0 -> behaves as 1: 16 upd_en, iter_cnt=1, then OUT.
//  abort asserted in TAP of iteration 1 -> IDLE next cycle, busy=0, no done; new go restarts cleanly from LOAD.
//  go pulsed during TAP -> ignored. rst asserted mid-OUT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pcnn_iter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcnn_iter_ctrl_pkg
//  Purpose  : Shared state encoding and width helper for the PCNN iteration
//             sequencer, its wrap counter, the datapath and the bench.
//  Contents : state_t  - sequencer states (IDLE, LOAD, TAP, UPD, OUT, DONE)
//             wbits()  - $clog2 clamped to a minimum of 1 bit
//  Revision : 1.0 - initial release
// ============================================================================
package pcnn_iter_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TAP  = 3'd2,
    S_UPD  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Counter width for n states; a single-state counter still needs one bit.
  function automatic int wbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcnn_iter_ctrl_wrap_cnt2d.sv
`default_nettype none
// ============================================================================
//  Module   : pcnn_wrap_cnt2d
//  Purpose  : Two-level wrap counter (outer hi, inner lo). The inner digit
//             counts 0..N0-1; on its wrap the outer digit steps 0..N1-1 and
//             wraps too, so the beat after (N1-1,N0-1) lands on (0,0).
//  Ports    : clk, rst (async, active-high)
//             clr  - synchronous clear to (0,0), wins over inc
//             inc  - advance one position
//             hi   - outer index, lo - inner index
//             last - currently at (N1-1,N0-1)
//  Revision : 1.0 - initial release
// ============================================================================
module pcnn_wrap_cnt2d
  import pcnn_iter_ctrl_pkg::*;
#(
  parameter int N1 = 2,
  parameter int N0 = 2,
  localparam int W1 = wbits(N1),
  localparam int W0 = wbits(N0)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [W1-1:0] hi,
  output logic [W0-1:0] lo,
  output logic          last
);

  localparam logic [W1-1:0] HI_MAX = W1'(N1 - 1);
  localparam logic [W0-1:0] LO_MAX = W0'(N0 - 1);

  logic hi_end;
  logic lo_end;

  assign hi_end = (hi == HI_MAX);
  assign lo_end = (lo == LO_MAX);
  assign last   = hi_end && lo_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (clr) begin
      hi <= '0;
      lo <= '0;
    end else if (inc) begin
      if (lo_end) begin
        lo <= '0;
        hi <= hi_end ? '0 : hi + W1'(1);
      end else begin
        lo <= lo + W0'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcnn_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pcnn_iter_ctrl
//  Purpose  : Sequencer for the PCNN image datapath: load image, run n_iter
//             sweeps of (kernel accumulate per pixel -> neuron update), then
//             stream pulse pixels out. Owns pixel and kernel counters.
//  Ports    : go/n_iter/abort        - control (n_iter latched on go, 0 -> 1)
//             in_valid/in_ready      - stimulus pixel handshake (LOAD)
//             out_valid/out_ready    - pulse pixel handshake (OUT)
//             row/col, krow/kcol     - current pixel and kernel tap
//             ld_en/acc_clr/acc_en/upd_en - datapath strobes
//             iter_cnt/busy/done     - status
//  Revision : 1.0 - initial release
// ============================================================================
module pcnn_iter_ctrl
  import pcnn_iter_ctrl_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int KSIZE = 3,
  parameter int IW    = 4,
  localparam int RW = wbits(ROWS),
  localparam int CW = wbits(COLS),
  localparam int KW = wbits(KSIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [IW-1:0] n_iter,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [KW-1:0] krow,
  output logic [KW-1:0] kcol,
  output logic          ld_en,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          upd_en,
  output logic [IW-1:0] iter_cnt,
  output logic          busy,
  output logic          done
);

  state_t        state, state_nxt;
  logic [IW-1:0] n_lat;

  logic pix_inc, pix_clr, pix_last;
  logic k_inc, k_clr, k_last;
  logic iter_inc, iter_clr, latch;

  pcnn_wrap_cnt2d #(.N1(ROWS), .N0(COLS)) u_pix (
    .clk  (clk),
    .rst  (rst),
    .clr  (pix_clr),
    .inc  (pix_inc),
    .hi   (row),
    .lo   (col),
    .last (pix_last)
  );

  pcnn_wrap_cnt2d #(.N1(KSIZE), .N0(KSIZE)) u_tap (
    .clk  (clk),
    .rst  (rst),
    .clr  (k_clr),
    .inc  (k_inc),
    .hi   (krow),
    .lo   (kcol),
    .last (k_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      n_lat    <= '0;
      iter_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (latch)
        n_lat <= (n_iter == '0) ? IW'(1) : n_iter;
      if (iter_clr)
        iter_cnt <= '0;
      else if (iter_inc)
        iter_cnt <= iter_cnt + IW'(1);
    end
  end

  // Counters wrap to (0,0) on their own after the last position, so the
  // LOAD->TAP, TAP->UPD and UPD->OUT hand-offs need no explicit clear.
  always_comb begin
    state_nxt = state;
    pix_inc   = 1'b0;
    pix_clr   = 1'b0;
    k_inc     = 1'b0;
    k_clr     = 1'b0;
    iter_inc  = 1'b0;
    iter_clr  = 1'b0;
    latch     = 1'b0;

    case (state)
      S_IDLE: begin
        if (go) begin
          state_nxt = S_LOAD;
          latch     = 1'b1;
          pix_clr   = 1'b1;
          k_clr     = 1'b1;
          iter_clr  = 1'b1;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          pix_inc = 1'b1;
          if (pix_last) state_nxt = S_TAP;
        end
      end
      S_TAP: begin
        k_inc = 1'b1;
        if (k_last) state_nxt = S_UPD;
      end
      S_UPD: begin
        pix_inc   = 1'b1;
        k_clr     = 1'b1;
        state_nxt = S_TAP;
        if (pix_last) begin
          iter_inc = 1'b1;
          if ((iter_cnt + IW'(1)) == n_lat) state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          pix_inc = 1'b1;
          if (pix_last) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        pix_clr   = 1'b1;
        k_clr     = 1'b1;
        iter_clr  = 1'b1;
      end
    endcase

    // Abort overrides whatever the state decided above.
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      pix_inc   = 1'b0;
      k_inc     = 1'b0;
      iter_inc  = 1'b0;
      latch     = 1'b0;
      pix_clr   = 1'b1;
      k_clr     = 1'b1;
      iter_clr  = 1'b1;
    end
  end

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_OUT);
  assign ld_en     = (state == S_LOAD) && in_valid;
  assign acc_en    = (state == S_TAP);
  assign acc_clr   = (state == S_TAP) && (krow == '0) && (kcol == '0);
  assign upd_en    = (state == S_UPD);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule
`default_nettype wire
